// File: rtl/icache_l1.sv
// icache_l1: set-associative L1 instruction cache with tree-PLRU replacement,
// fence.i flush-all and a two-line buffer that serves hits with zero wait.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   pc                 fetch address (bit 0 ignored)
//   ir, stall_imem     instruction at pc, 1 = ir not valid yet
//   stall              pipeline stall, freezes PLRU update on lookup hits
//   flush              fence.i pulse, invalidates every line
//   b_addr_i, b_rd_i   bus line request, held until b_dv_i
//   b_data_i, b_dv_i   bus line data with one-cycle valid pulse
module icache_l1 #(
    parameter int XLEN = 64,
    parameter int WAYS = 4,
    parameter int SETS = 64,
    parameter int LINE = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic [31:0]     ir,
    output logic            stall_imem,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] b_addr_i,
    output logic            b_rd_i,
    input  logic [LINE-1:0] b_data_i,
    input  logic            b_dv_i
);
    localparam int OFFS = $clog2(LINE / 8);
    localparam int SETW = $clog2(SETS);
    localparam int TAGW = XLEN - OFFS - SETW;
    localparam int WAYW = $clog2(WAYS);
    localparam int LAW  = XLEN - OFFS;

    typedef enum logic [1:0] {READY, LOOKUP, REFILL, FLUSH} state_t;

    state_t state_q, state_d;
    logic [LAW-1:0]  tgt_q, tgt_d;
    logic            slot_q, slot_d;
    logic [SETW-1:0] fcnt_q, fcnt_d;
    logic            fpend_q, fpend_d;

    logic [TAGW-1:0] tag_q  [SETS][WAYS];
    logic [LINE-1:0] data_q [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [SETS-1:0][WAYS-2:0] plru_q;

    logic [1:0]           lb_val_q;
    logic [1:0][LAW-1:0]  lb_addr_q;
    logic [1:0][LINE-1:0] lb_data_q;

    // Tree-PLRU, heap-ordered nodes (node n at bit n-1); a node bit
    // of 1 points at the right subtree.
    function automatic logic [WAYW-1:0] plru_vic(input logic [WAYS-2:0] t);
        int n;
        n = 1;
        for (int l = 0; l < WAYW; l++) n = 2 * n + int'(t[n-1]);
        return WAYW'(n - WAYS);
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                   input logic [WAYW-1:0] w);
        logic [WAYS-2:0] r;
        int n;
        r = t;
        n = 1;
        for (int l = 0; l < WAYW; l++) begin
            r[n-1] = ~w[WAYW-1-l];
            n = 2 * n + int'(w[WAYW-1-l]);
        end
        return r;
    endfunction

    logic [LAW-1:0]   line0, line1;
    logic [OFFS-1:0]  offs;
    logic [OFFS+2:0]  bpos;
    logic [LINE+15:0] win;
    logic             straddle, hit0, hit1, lb_hit;
    logic             unused_pc0;

    assign line0    = pc[XLEN-1:OFFS];
    assign line1    = line0 + LAW'(1);
    assign offs     = {pc[OFFS-1:1], 1'b0};
    assign bpos     = {offs, 3'b000};
    assign straddle = (offs == OFFS'(LINE / 8 - 2));
    assign hit0     = lb_val_q[0] && (lb_addr_q[0] == line0);
    assign hit1     = lb_val_q[1] && (lb_addr_q[1] == line1);
    assign lb_hit   = hit0 && (!straddle || hit1);
    assign unused_pc0 = pc[0];

    // A straddling fetch reads past the end of LB0 into the low half of LB1.
    assign win        = {lb_data_q[1][15:0], lb_data_q[0]};
    assign stall_imem = !(state_q == READY && lb_hit && !flush);
    assign ir         = stall_imem ? 32'h0 : win[bpos +: 32];
    assign b_rd_i     = (state_q == REFILL);
    assign b_addr_i   = b_rd_i ? {tgt_q, {OFFS{1'b0}}} : '0;

    logic [SETW-1:0] tset;
    logic [TAGW-1:0] ttag;
    logic [WAYW-1:0] hit_way, inv_way, victim;
    logic            hit, has_inv, fill, lk_hit;

    assign tset = tgt_q[SETW-1:0];
    assign ttag = tgt_q[LAW-1:SETW];

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[tset][w]) begin
                has_inv = 1'b1;
                inv_way = WAYW'(w);
            end
            if (valid_q[tset][w] && tag_q[tset][w] == ttag) begin
                hit     = 1'b1;
                hit_way = WAYW'(w);
            end
        end
    end

    assign victim = has_inv ? inv_way : plru_vic(plru_q[tset]);
    assign fill   = (state_q == REFILL) && b_dv_i && !flush && !fpend_q;
    assign lk_hit = (state_q == LOOKUP) && !flush && hit;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        slot_d  = slot_q;
        fcnt_d  = fcnt_q;
        fpend_d = fpend_q;
        unique case (state_q)
            READY: begin
                if (flush) begin
                    state_d = FLUSH;
                    fcnt_d  = '0;
                end else if (!lb_hit) begin
                    state_d = LOOKUP;
                    tgt_d   = hit0 ? line1 : line0;
                    slot_d  = hit0;
                end
            end
            LOOKUP: begin
                if (flush) begin
                    state_d = FLUSH;
                    fcnt_d  = '0;
                end else begin
                    state_d = hit ? READY : REFILL;
                end
            end
            REFILL: begin
                // The bus transfer is never abandoned; a pending flush
                // only suppresses the install.
                if (flush) fpend_d = 1'b1;
                if (b_dv_i) begin
                    if (flush || fpend_q) begin
                        state_d = FLUSH;
                        fcnt_d  = '0;
                        fpend_d = 1'b0;
                    end else begin
                        state_d = READY;
                    end
                end
            end
            FLUSH: begin
                if (flush) begin
                    fcnt_d = '0;
                end else if (fcnt_q == SETW'(SETS - 1)) begin
                    state_d = READY;
                end else begin
                    fcnt_d = fcnt_q + SETW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[tset][victim]  <= ttag;
            data_q[tset][victim] <= b_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= READY;
            tgt_q     <= '0;
            slot_q    <= 1'b0;
            fcnt_q    <= '0;
            fpend_q   <= 1'b0;
            valid_q   <= '0;
            plru_q    <= '0;
            lb_val_q  <= '0;
            lb_addr_q <= '0;
            lb_data_q <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            slot_q  <= slot_d;
            fcnt_q  <= fcnt_d;
            fpend_q <= fpend_d;
            if (state_q == FLUSH) begin
                valid_q[fcnt_q] <= '0;
                plru_q[fcnt_q]  <= '0;
                lb_val_q        <= '0;
            end
            if (fill) begin
                valid_q[tset][victim] <= 1'b1;
                plru_q[tset]          <= plru_touch(plru_q[tset], victim);
                lb_val_q[slot_q]      <= 1'b1;
                lb_addr_q[slot_q]     <= tgt_q;
                lb_data_q[slot_q]     <= b_data_i;
            end
            if (lk_hit) begin
                lb_val_q[slot_q]  <= 1'b1;
                lb_addr_q[slot_q] <= tgt_q;
                lb_data_q[slot_q] <= data_q[tset][hit_way];
                if (!stall) plru_q[tset] <= plru_touch(plru_q[tset], hit_way);
            end
        end
    end
endmodule

// File: tb/tb_icache_l1.sv
// tb_icache_l1: directed bench for icache_l1 with a fixed-latency bus
// responder whose 32-bit words equal their own byte address.
module tb_icache_l1;
    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  pc;
    logic [31:0]  ir;
    logic         stall_imem;
    logic         stall;
    logic         flush;
    logic [63:0]  b_addr_i;
    logic         b_rd_i;
    logic [255:0] b_data_i;
    logic         b_dv_i;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int rd_cnt = 0;

    icache_l1 dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .ir         (ir),
        .stall_imem (stall_imem),
        .stall      (stall),
        .flush      (flush),
        .b_addr_i   (b_addr_i),
        .b_rd_i     (b_rd_i),
        .b_data_i   (b_data_i),
        .b_dv_i     (b_dv_i)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mk_line(input logic [63:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = a[31:0] + 32'(4 * k);
        return l;
    endfunction

    initial begin
        b_dv_i   = 1'b0;
        b_data_i = '0;
        forever begin
            @(negedge clk);
            if (b_rd_i) begin
                rd_cnt++;
                if (rd_cnt == LAT) begin
                    b_dv_i   = 1'b1;
                    b_data_i = mk_line(b_addr_i);
                    dv_cnt++;
                end else begin
                    b_dv_i = 1'b0;
                end
            end else begin
                rd_cnt = 0;
                b_dv_i = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    task automatic fetch(input logic [63:0] a, input bit rel,
                         output int waits, output logic [31:0] got,
                         output int buses);
        int d0;
        d0 = dv_cnt;
        @(negedge clk);
        pc = a;
        if (rel) rst = 1'b0;
        #1;
        waits = 0;
        while (stall_imem && waits < 100) begin
            @(posedge clk);
            #1;
            waits++;
        end
        got   = ir;
        buses = dv_cnt - d0;
    endtask

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ir;
        int          w;
        int          b;
    } vec_t;

    vec_t vt[17];

    initial begin
        int w, bs, n, hold, gap;
        logic [31:0] got;
        bit sok;

        vt[0]  = '{64'h1000, 32'h0000_1000, 7, 1};
        vt[1]  = '{64'h1004, 32'h0000_1004, 0, 0};
        vt[2]  = '{64'h1002, 32'h1004_0000, 0, 0};
        vt[3]  = '{64'h101C, 32'h0000_101C, 0, 0};
        vt[4]  = '{64'h101E, 32'h1020_0000, 7, 1};
        vt[5]  = '{64'h1020, 32'h0000_1020, 2, 0};
        vt[6]  = '{64'h1000, 32'h0000_1000, 2, 0};
        vt[7]  = '{64'h103E, 32'h1040_0000, 9, 1};
        vt[8]  = '{64'h1800, 32'h0000_1800, 7, 1};
        vt[9]  = '{64'h2000, 32'h0000_2000, 7, 1};
        vt[10] = '{64'h2800, 32'h0000_2800, 7, 1};
        vt[11] = '{64'h1000, 32'h0000_1000, 2, 0};
        vt[12] = '{64'h3000, 32'h0000_3000, 7, 1};
        vt[13] = '{64'h1000, 32'h0000_1000, 2, 0};
        vt[14] = '{64'h1800, 32'h0000_1800, 2, 0};
        vt[15] = '{64'h2000, 32'h0000_2000, 7, 1};
        vt[16] = '{64'h3000, 32'h0000_3000, 2, 0};

        rst   = 1'b1;
        pc    = 64'h1000;
        stall = 1'b0;
        flush = 1'b0;
        #3;
        chk("rst_ir", 64'(ir), 64'h0);
        chk("rst_stall", 64'(stall_imem), 64'h1);
        chk("rst_rd", 64'(b_rd_i), 64'h0);
        chk("rst_addr", b_addr_i, 64'h0);

        for (int i = 0; i < 17; i++) begin
            fetch(vt[i].pc, i == 0, w, got, bs);
            chk($sformatf("v%0d_waits", i), 64'(w), 64'(vt[i].w));
            chk($sformatf("v%0d_ir", i), 64'(got), 64'(vt[i].ir));
            chk($sformatf("v%0d_bus", i), 64'(bs), 64'(vt[i].b));
        end

        // fence.i in the middle of a refill
        @(negedge clk);
        pc = 64'h4000;
        hold = 0;
        n = 0;
        while (n < 200) begin
            if (b_rd_i) hold++;
            else if (hold > 0) break;
            flush = (hold == 2);
            @(negedge clk);
            n++;
        end
        flush = 1'b0;
        chk("flush_rd_hold", 64'(hold), 64'(LAT));
        gap = 0;
        sok = 1'b1;
        while (!b_rd_i && gap < 200) begin
            gap++;
            if (!stall_imem) sok = 1'b0;
            @(negedge clk);
        end
        chk("flush_gap", 64'(gap), 64'd66);
        chk("flush_stall", 64'(sok), 64'h1);
        chk("flush_refetch_addr", b_addr_i, 64'h4000);
        n = 0;
        while (stall_imem && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("flush_refetch_ir", 64'(ir), 64'h4000);

        // reset in the middle of a refill
        @(negedge clk);
        pc = 64'h5000;
        n = 0;
        while (!b_rd_i && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_rd_seen", 64'(b_rd_i), 64'h1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_rd", 64'(b_rd_i), 64'h0);
        chk("rst_mid_stall", 64'(stall_imem), 64'h1);
        pc = 64'h1000;
        fetch(64'h1000, 1'b1, w, got, bs);
        chk("rst_refetch_waits", 64'(w), 64'd7);
        chk("rst_refetch_bus", 64'(bs), 64'd1);
        chk("rst_refetch_ir", 64'(got), 64'h1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
